burst_mem_arbiter: RTL and testbench

N-channel line-level arbiter and burst adaptor between the cache hierarchy (I$, D$, L2, prefetcher, EWB) and the single burst-memory port of mp4.
- Each channel issues whole-line reads or writes.
- The block serialises them onto the memory port as BEATS consecutive beats and reassembles read lines.
- It generalises the fixed two-port I/D arbitration to NUM_CH channels with parametrised line and beat widths.

---
 rtl/burst_arb_pkg.sv | 30 +++
 rtl/burst_mem_arbiter_rr_grant.sv | 63 ++++++
 rtl/burst_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_burst_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_arb_pkg.sv
// burst_arb_pkg: shared state encoding and geometry helpers for burst_mem_arbiter.
`default_nettype none

package burst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int calc_beats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // A single-beat line still needs a one-bit counter.
    function automatic int calc_cnt_w(input int line_w, input int beat_w);
        int beats;
        beats = calc_beats(line_w, beat_w);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic int calc_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/burst_mem_arbiter_rr_grant.sv
// rr_grant: picks one requesting channel; round-robin when BURST_ARB_RR_EN is defined,
// lowest-index fixed priority otherwise.
`default_nettype none

module rr_grant
    import burst_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = calc_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              update,
    input  logic [IDX_W-1:0]  last_idx,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx
);

`ifdef BURST_ARB_RR_EN
    logic [IDX_W-1:0] ptr;

    // ptr holds the channel where the next search starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (int'(last_idx) >= NUM_CH - 1) ? '0 : last_idx + 1'b1;
        end
    end

    always_comb begin
        int c;
        c           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (req[c]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(c);
            end
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end

    logic unused_rr;
    assign unused_rr = &{1'b0, clk, rst, update, last_idx};
`endif

endmodule

`default_nettype wire

// File: rtl/burst_mem_arbiter.sv
// burst_mem_arbiter: NUM_CH line requesters serialised onto one burst memory port.
// Optional round-robin arbitration via BURST_ARB_RR_EN.
`default_nettype none

module burst_mem_arbiter
    import burst_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BEAT_W-1:0]        mem_wdata,
    input  logic [BEAT_W-1:0]        mem_rdata,
    input  logic                     mem_resp
);

    localparam int BEATS = calc_beats(LINE_W, BEAT_W);
    localparam int CNT_W = calc_cnt_w(LINE_W, BEAT_W);
    localparam int IDX_W = calc_idx_w(NUM_CH);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   sel;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wline;
    logic [LINE_W-1:0]  rbuf;
    logic [NUM_CH-1:0]  req;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               last_beat;

    assign req       = ch_read | ch_write;
    assign last_beat = mem_resp && (cnt == LAST_BEAT);
    assign ch_rdata  = rbuf;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .update      (state == DONE),
        .last_idx    (sel),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ch_resp   = '0;
        case (state)
            IDLE: begin
                // Write wins when a channel raises both directions.
                if (grant_valid) begin
                    state_nxt = ch_write[grant_idx] ? WR : RD;
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wline[int'(cnt)*BEAT_W +: BEAT_W];
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ch_resp[sel] = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            sel    <= '0;
            addr_q <= '0;
            wline  <= '0;
            rbuf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        sel    <= grant_idx;
                        addr_q <= ch_addr[int'(grant_idx)*ADDR_W +: ADDR_W] & ALIGN_MASK;
                        if (ch_write[grant_idx]) begin
                            wline <= ch_wdata[int'(grant_idx)*LINE_W +: LINE_W];
                        end
                    end
                end
                RD: begin
                    if (mem_resp) begin
                        rbuf[int'(cnt)*BEAT_W +: BEAT_W] <= mem_rdata;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (mem_resp) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_burst_mem_arbiter.sv
// tb_burst_mem_arbiter: scoreboard bench with a beat-level memory model and random stalls.
`default_nettype none

module tb_burst_mem_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
`ifdef BURST_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        ch_read = '0;
    logic [NUM_CH-1:0]        ch_write = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_addr = '0;
    logic [NUM_CH*LINE_W-1:0] ch_wdata = '0;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     mem_read, mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [BEAT_W-1:0]        mem_wdata;
    logic [BEAT_W-1:0]        mem_rdata = '0;
    logic                     mem_resp = 1'b0;

    burst_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: written lines, otherwise an address-derived pattern.
    logic [LINE_W-1:0] mem_model [logic [ADDR_W-1:0]];

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        if (a == 32'h0000_1220)
            return {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int b = 0; b < BEATS; b++) l[b*BEAT_W +: BEAT_W] = {a, 32'hC0DE_0000 | 32'(b)};
        return l;
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_W / 8 - 1);
    endfunction

    // ---------------- memory responder ----------------
    int                max_stall = 0;
    int                stray_cnt = 0;
    int                beat = 0;
    bit                in_burst = 0, done_wait = 0, drop_seen = 0, burst_wr = 0, last_wr = 0;
    logic [ADDR_W-1:0] burst_addr = '0, last_addr = '0;
    logic [LINE_W-1:0] cur_line = '0;
    int                last_resp_cyc = -1;

    initial begin
        int stall;
        int stray_done;
        stall = 0;
        stray_done = 0;
        forever begin
            @(negedge clk);
            mem_resp = 1'b0;
            if (!rst) begin
                in_burst  = 0;
                done_wait = 0;
                beat      = 0;
            end else if (done_wait) begin
                if (!(mem_read || mem_write)) begin
                    done_wait = 0;
                    in_burst  = 0;
                end
            end else if (mem_read || mem_write) begin
                if (!in_burst) begin
                    in_burst   = 1;
                    beat       = 0;
                    drop_seen  = 0;
                    burst_addr = mem_addr;
                    burst_wr   = mem_write;
                    cur_line   = line_of(mem_addr);
                    stall      = int'($urandom_range(max_stall, 0));
                end
                if (mem_addr !== burst_addr || mem_write !== burst_wr || mem_read === mem_write)
                    drop_seen = 1;
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_resp = 1'b1;
                    if (burst_wr) cur_line[beat*BEAT_W +: BEAT_W] = mem_wdata;
                    else          mem_rdata = cur_line[beat*BEAT_W +: BEAT_W];
                    beat++;
                    last_resp_cyc = cyc + 1;
                    stall = int'($urandom_range(max_stall, 0));
                    if (beat == BEATS) begin
                        done_wait = 1;
                        if (burst_wr) mem_model[burst_addr] = cur_line;
                        last_addr = burst_addr;
                        last_wr   = burst_wr;
                        check_eq("burst_held", LINE_W'(drop_seen), '0);
                    end
                end
            end else if (in_burst) begin
                in_burst = 0;
                checks++;
                errors++;
                $display("FAIL burst_dropped: got beat %0d expected %0d", beat, BEATS);
            end else if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                mem_resp   = 1'b1;
            end
        end
    end

    // ---------------- requester driver + scoreboard ----------------
    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t              exp_q [NUM_CH][$];
    bit                req_wr     [NUM_CH];
    logic [ADDR_W-1:0] req_addr   [NUM_CH];
    logic [LINE_W-1:0] req_data   [NUM_CH];
    int                req_repeat [NUM_CH];
    int                issue_cnt  [NUM_CH];
    bit                busy       [NUM_CH];
    int                grant_log[$];
    int                resp_count = 0;

    initial begin
        int   applied [NUM_CH];
        int   rem     [NUM_CH];
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            applied[i] = 0; rem[i] = 0; busy[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                ch_read  = '0;
                ch_write = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    exp_q[i].delete();
                    busy[i] = 0;
                end
            end else begin
                if (ch_resp != '0) begin
                    resp_count++;
                    check_eq("resp_onehot", LINE_W'($countones(ch_resp)), LINE_W'(1));
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_resp[i]) begin
                        grant_log.push_back(i);
                        check_eq("resp_latency", LINE_W'(cyc), LINE_W'(last_resp_cyc));
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_resp: got resp on ch %0d expected none", i);
                        end else begin
                            e = exp_q[i].pop_front();
                            check_eq("mem_addr", LINE_W'(last_addr), LINE_W'(e.addr));
                            check_eq("direction", LINE_W'(last_wr), LINE_W'(e.wr));
                            if (e.wr) check_eq("write_line", line_of(e.addr), e.data);
                            else      check_eq("read_line", ch_rdata, e.data);
                        end
                        if (rem[i] > 0) begin
                            rem[i]--;
                            e.wr   = req_wr[i];
                            e.addr = align(req_addr[i]);
                            e.data = req_wr[i] ? req_data[i] : line_of(align(req_addr[i]));
                            exp_q[i].push_back(e);
                        end else begin
                            ch_read[i]  = 1'b0;
                            ch_write[i] = 1'b0;
                            busy[i]     = 0;
                        end
                    end
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (issue_cnt[i] != applied[i]) begin
                        applied[i] = issue_cnt[i];
                        rem[i]     = req_repeat[i];
                        busy[i]    = 1;
                        ch_addr[i*ADDR_W +: ADDR_W]  = req_addr[i];
                        ch_wdata[i*LINE_W +: LINE_W] = req_data[i];
                        ch_write[i] = req_wr[i];
                        ch_read[i]  = !req_wr[i];
                        e.wr   = req_wr[i];
                        e.addr = align(req_addr[i]);
                        e.data = req_wr[i] ? req_data[i] : line_of(align(req_addr[i]));
                        exp_q[i].push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int model_ptr = 0;
    int exp_order[$];

    task automatic issue(input int ch, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d, input int repeats);
        req_wr[ch]     = wr;
        req_addr[ch]   = a;
        req_data[ch]   = d;
        req_repeat[ch] = repeats;
        issue_cnt[ch]  = issue_cnt[ch] + 1;
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic wait_all();
        bit idle;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            #1;
            idle = 1;
            for (int i = 0; i < NUM_CH; i++) if (busy[i]) idle = 0;
            if (idle) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got pending requests expected all served");
        finish_sim();
    endtask

    // Grant order for simultaneous pending request counts, from the arbitration rule.
    task automatic predict_order(input int n[NUM_CH]);
        int left [NUM_CH];
        int total, pick, start;
        total = 0;
        for (int i = 0; i < NUM_CH; i++) begin left[i] = n[i]; total += n[i]; end
        exp_order.delete();
        for (int s = 0; s < total; s++) begin
            start = RR ? model_ptr : 0;
            pick  = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (pick < 0 && left[(start + k) % NUM_CH] > 0) pick = (start + k) % NUM_CH;
            left[pick]--;
            exp_order.push_back(pick);
            model_ptr = (pick + 1) % NUM_CH;
        end
    endtask

    task automatic compare_order(input string name);
        check_eq({name, "_count"}, LINE_W'(grant_log.size()), LINE_W'(exp_order.size()));
        for (int k = 0; k < exp_order.size() && k < grant_log.size(); k++)
            check_eq(name, LINE_W'(grant_log[k]), LINE_W'(exp_order[k]));
    endtask

    initial begin
        int                n [NUM_CH];
        int                rc;
        logic [LINE_W-1:0] d;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < NUM_CH; i++) begin
            issue_cnt[i] = 0; req_repeat[i] = 0; req_wr[i] = 0; req_addr[i] = '0; req_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_mem_read", LINE_W'(mem_read), '0);
        check_eq("rst_mem_write", LINE_W'(mem_write), '0);
        check_eq("rst_mem_addr", LINE_W'(mem_addr), '0);
        check_eq("rst_mem_wdata", LINE_W'(mem_wdata), '0);
        check_eq("rst_ch_resp", LINE_W'(ch_resp), '0);
        check_eq("rst_ch_rdata", ch_rdata, '0);
        @(negedge clk);
        rst = 1'b1;

        // Single directed read and write.
        @(negedge clk);
        issue(0, 1'b0, 32'h0000_1234, '0, 0);
        wait_all();
        model_ptr = 1;
        @(negedge clk);
        issue(1, 1'b1, 32'h0000_0040, {{2{64'hAAAA_AAAA_AAAA_AAAA}}, {2{64'hBBBB_BBBB_BBBB_BBBB}}}, 0);
        wait_all();
        model_ptr = 2;

        // Two channels re-requesting back-to-back.
        grant_log.delete();
        @(negedge clk);
        issue(0, 1'b0, 32'h0000_0200, '0, 3);
        issue(1, 1'b1, 32'h0000_0300, {8{32'h5A5A_0300}}, 3);
        n = '{4, 4, 0, 0};
        predict_order(n);
        wait_all();
        compare_order("arb_order");

        // Reset during the second read beat.
        max_stall = 2;
        @(negedge clk);
        issue(0, 1'b0, 32'h0000_0500, '0, 0);
        for (int t = 0; t < 200 && !(in_burst && beat == 1); t++) begin
            @(negedge clk);
            #1;
        end
        check_eq("abort_point", LINE_W'(beat), LINE_W'(1));
        #2 rst = 1'b0;
        #1;
        check_eq("abort_mem_read", LINE_W'(mem_read), '0);
        check_eq("abort_mem_addr", LINE_W'(mem_addr), '0);
        check_eq("abort_ch_resp", LINE_W'(ch_resp), '0);
        check_eq("abort_ch_rdata", ch_rdata, '0);
        rc = resp_count;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr = 0;
        repeat (6) @(negedge clk);
        check_eq("abort_no_resp", LINE_W'(resp_count), LINE_W'(rc));
        issue(0, 1'b0, 32'h0000_0500, '0, 0);
        wait_all();
        model_ptr = 1;

        // Stray beat acknowledge while idle.
        rc = resp_count;
        @(negedge clk);
        stray_cnt = stray_cnt + 1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("stray_no_resp", LINE_W'(resp_count), LINE_W'(rc));
        check_eq("stray_no_burst", LINE_W'(mem_read | mem_write), '0);
        issue(2, 1'b0, 32'h0000_0880, '0, 0);
        wait_all();
        model_ptr = 3;

        // All channels at once with random stalls; first round reads only.
        max_stall = 5;
        for (int r = 0; r < 6; r++) begin
            grant_log.delete();
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                a = ADDR_W'(i * 32'h1000) + ADDR_W'($urandom_range(63, 0) * 32) + ADDR_W'($urandom_range(31, 0));
                d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                issue(i, (r == 0) ? 1'b0 : 1'($urandom_range(1, 0)), a, d, 0);
                n[i] = 1;
            end
            predict_order(n);
            wait_all();
            compare_order("round_order");
        end

        finish_sim();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
